// File: rtl/spi_adc_scanner.sv
// rtl/spi_adc_scanner.sv - round-robin scanner for an MCP3208-class SPI ADC, tagged samples plus per-channel hold
// Optional THRESH_CMP_EN adds a thresh input and a per-channel above output.
module spi_adc_scanner #(
  parameter int N_CH    = 8,
  parameter int DATA_W  = 12,
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   scan_en,
  input  logic                   start,
  input  logic [N_CH-1:0]        ch_mask,
  input  logic                   miso,
  output logic                   mosi,
  output logic                   sck,
  output logic                   cs_n,
  output logic [DATA_W-1:0]      sample_data,
  output logic [2:0]             sample_ch,
  output logic                   sample_valid,
  output logic                   busy,
  output logic [N_CH*DATA_W-1:0] last_val
`ifdef THRESH_CMP_EN
  ,
  input  logic [DATA_W-1:0]      thresh,
  output logic [N_CH-1:0]        above
`endif
);

  localparam int FRAME_LEN = 9 + DATA_W;
  localparam int BIT_W     = $clog2(FRAME_LEN);
  localparam int CNT_MAX   = (2 * CLK_DIV > GAP_CYC) ? 2 * CLK_DIV : GAP_CYC;
  localparam int CNT_W     = $clog2(CNT_MAX);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [2:0]             ch_q, ch_d;
  logic [2:0]             ptr_q, ptr_d;
  logic                   pass_q, pass_d;
  logic [DATA_W-1:0]      sr_q, sr_d;
  logic                   cs_n_q, cs_n_d;
  logic                   sck_q, sck_d;
  logic                   mosi_q, mosi_d;
  logic                   busy_q, busy_d;
  logic                   sv_q, sv_d;
  logic [DATA_W-1:0]      sd_q, sd_d;
  logic [2:0]             sch_q, sch_d;
  logic [N_CH*DATA_W-1:0] lv_q, lv_d;
  logic [3:0]             nxt;
`ifdef THRESH_CMP_EN
  logic [N_CH-1:0]        above_q, above_d;
`endif

  // {found, channel}: lowest enabled channel at or above base, optionally wrapping to 0
  function automatic logic [3:0] pick(input logic [N_CH-1:0] m, input logic [3:0] base,
                                      input logic wrap);
    logic [3:0] r;
    r = 4'd0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (m[i] && (i >= int'(base))) r = {1'b1, 3'(i)};
    if (!r[3] && wrap)
      for (int i = N_CH - 1; i >= 0; i--)
        if (m[i]) r = {1'b1, 3'(i)};
    return r;
  endfunction

  // Command bits go out MSB first; everything past the null bit is driven low
  function automatic logic frame_bit(input logic [BIT_W-1:0] b, input logic [2:0] ch);
    logic [8:0] t;
    t = {2'b11, ch, 4'b0000} << b;
    return t[8];
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    pass_d  = pass_q;
    sr_d    = sr_q;
    cs_n_d  = cs_n_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    sv_d    = 1'b0;
    sd_d    = sd_q;
    sch_d   = sch_q;
    lv_d    = lv_q;
    nxt     = 4'd0;
`ifdef THRESH_CMP_EN
    above_d = above_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) nxt = pick(ch_mask, 4'd0, 1'b0);
        else if (scan_en) nxt = pick(ch_mask, {1'b0, ptr_q}, 1'b1);
        if (nxt[3]) begin
          state_d = S_SETUP;
          ch_d    = nxt[2:0];
          pass_d  = start;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          mosi_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      S_SETUP: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          sck_d = 1'b1;
          if (bit_q >= BIT_W'(9)) sr_d = DATA_W'({sr_q, miso});
        end
        if (cnt_q == CNT_W'(2 * CLK_DIV - 1)) begin
          sck_d = 1'b0;
          cnt_d = '0;
          if (bit_q == BIT_W'(FRAME_LEN - 1)) begin
            state_d = S_HOLD;
            mosi_d  = 1'b0;
          end else begin
            bit_d  = bit_q + BIT_W'(1);
            mosi_d = frame_bit(bit_q + BIT_W'(1), ch_q);
          end
        end
      end
      S_HOLD: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          state_d = S_GAP;
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          sv_d    = 1'b1;
          sd_d    = sr_q;
          sch_d   = ch_q;
          ptr_d   = (ch_q == 3'(N_CH - 1)) ? 3'd0 : ch_q + 3'd1;
          for (int i = 0; i < N_CH; i++) begin
            if (ch_q == 3'(i)) begin
              lv_d[i*DATA_W +: DATA_W] = sr_q;
`ifdef THRESH_CMP_EN
              above_d[i] = (sr_q > thresh);
`endif
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          // A start-pass only climbs upward; continuous scanning wraps around
          if (scan_en) nxt = pick(ch_mask, {1'b0, ptr_q}, 1'b1);
          else if (pass_q) nxt = pick(ch_mask, {1'b0, ch_q} + 4'd1, 1'b0);
          if (nxt[3]) begin
            state_d = S_SETUP;
            ch_d    = nxt[2:0];
            cs_n_d  = 1'b0;
            mosi_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            pass_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
      pass_q  <= 1'b0;
      sr_q    <= '0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      sv_q    <= 1'b0;
      sd_q    <= '0;
      sch_q   <= '0;
      lv_q    <= '0;
`ifdef THRESH_CMP_EN
      above_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      pass_q  <= pass_d;
      sr_q    <= sr_d;
      cs_n_q  <= cs_n_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      sv_q    <= sv_d;
      sd_q    <= sd_d;
      sch_q   <= sch_d;
      lv_q    <= lv_d;
`ifdef THRESH_CMP_EN
      above_q <= above_d;
`endif
    end
  end

  assign cs_n         = cs_n_q;
  assign sck          = sck_q;
  assign mosi         = mosi_q;
  assign busy         = busy_q;
  assign sample_valid = sv_q;
  assign sample_data  = sd_q;
  assign sample_ch    = sch_q;
  assign last_val     = lv_q;
`ifdef THRESH_CMP_EN
  assign above        = above_q;
`endif

endmodule

// File: doc/spi_adc_scanner.md
Name: spi_adc_scanner

Overview:
Parametrised successor to the single-channel 12-bit SPI ADC reader. Round-robin scans up to 8 single-ended channels of an MCP3208-class SPI ADC, with configurable data width and SCK divider. Emits one tagged sample per conversion and holds the latest value for each channel. Sits between the prescaled system clock and the LED/display logic in the top level.

Parameters:
N_CH, 8, number of channels scanned (1..8); channel index width CH_W = 3 (fixed).
DATA_W, 12, conversion result width (1..16).
CLK_DIV, 4, SCK half-period in clk cycles (>=1).
GAP_CYC, 8, CS-high idle cycles between frames (>=1).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
scan_en  in  1  level; 1 = continuous scanning
start  in  1  one-cycle pulse; run one pass over enabled channels
ch_mask  in  N_CH  channel enable mask, bit i = channel i
miso  in  1  ADC data out
mosi  out  1  ADC data in
sck  out  1  SPI clock, mode 0, idles low
cs_n  out  1  chip select, active low
sample_data  out  DATA_W  last converted value
sample_ch  out  3  channel of sample_data
sample_valid  out  1  one-cycle strobe on new sample
busy  out  1  high from frame start to end of last gap in a pass
last_val  out  N_CH*DATA_W  latest value per channel, channel i at [i*DATA_W +: DATA_W]

Behaviour:
- Reset (async): cs_n=1, sck=0, mosi=0, sample_valid=0, busy=0, sample_data=0, sample_ch=0, last_val=0, channel pointer=0, FSM=IDLE.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: if (scan_en or start) and ch_mask != 0 -> select lowest enabled channel >= pointer (wrap to 0); cs_n falls; -> SETUP. ch_mask==0: stay in IDLE, busy=0, start discarded.
- SETUP: CLK_DIV cycles, sck=0, mosi=first frame bit -> SHIFT.
- Frame bits, MSB first, FRAME_LEN = 9+DATA_W: 1 (start), 1 (single-ended), ch[2:0], 0,0,0, 1 null bit, then DATA_W data bits.
- SHIFT, per bit: CLK_DIV cycles sck=0 (mosi updated on the cycle sck falls), then CLK_DIV cycles sck=1. miso sampled into the shift register on the clk edge where sck rises, only for the last DATA_W bits. Bit duration = 2*CLK_DIV cycles.
- After the last bit: sck=0 -> HOLD for CLK_DIV cycles -> cs_n rises. On that same cycle: sample_valid=1 for 1 cycle; sample_data/sample_ch/last_val[ch] update. -> GAP.
- GAP: GAP_CYC cycles with cs_n=1. Then:
  - Next enabled channel (ascending, wrapping N_CH-1 -> 0) if scan_en=1, or if in a start-pass and enabled channels remain above the current one.
  - Otherwise -> IDLE.
- Frame period = CLK_DIV*(2+2*FRAME_LEN) + GAP_CYC cycles.
- start while busy: ignored. scan_en deasserted mid-frame: current frame completes, then IDLE.
- ch_mask is sampled only when choosing the next channel; a mid-frame change never aborts the frame.
- Pointer persists across passes; a start-pass always begins at channel 0.
- mosi=0 whenever cs_n=1.
- rst_n low mid-frame: immediate return to reset values; no sample_valid.

Optional Feature:
THRESH_CMP_EN
- Defined: adds input thresh [DATA_W-1:0] and output above [N_CH-1:0]. above[i] updates together with last_val[i] and equals (value > thresh). Reset value 0. Drives LED alarms.
- Undefined: neither port exists; no comparator logic.

Test Plan:
1. Reset: rst_n=0 mid-SHIFT -> cs_n=1, sck=0, sample_valid=0, last_val=0 within the same cycle.
2. Defaults, start pulse, ch_mask=8'h05, ADC model returns 0xABC for ch0 and 0x123 for ch2 -> exactly two sample_valid strobes (ch 0 then ch 2), last_val ch0=0xABC, ch2=0x123, busy falls, cs_n stays 1.
3. scan_en=1, ch_mask=8'h81 -> channel order 0,7,0,7. Frame period = 4*(2+42)+8 = 184 clks. mosi command for ch7 = 1,1,1,1,1,0,0,0.
4. CLK_DIV=1, DATA_W=10 -> sck period 2 clks, 19 sck rising edges per frame, 10-bit value captured correctly.
5. ch_mask=0 with scan_en=1 -> cs_n never falls, busy=0. Then ch_mask=8'h10 -> scanning begins on ch4.
6. THRESH_CMP_EN defined, thresh=0x800, samples 0x801 then 0x800 on ch3 -> above[3]=1, then 0.
